// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding word-aligned data memory behind the LSU.
// Accepts one request over valid/ready, commits it (read or byte-masked
// write) a fixed LATENCY cycles after accept, and holds the response
// until the requester takes it.
module dmem_responder #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned LATENCY     = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [XLEN-1:0] req_addr_i,
   input  logic [XLEN-1:0] req_wdata_i,
   input  logic [3:0]      req_wmask_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] rsp_rdata_o,
   output logic            rsp_err_o
);

   localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t            state;
   logic [3:0]        count;

   // request captured on the accept edge
   logic              we;
   logic [IDX_W-1:0]  idx;
   logic [XLEN-1:0]   wdata;
   logic [3:0]        wmask;
   logic              err;

   logic [XLEN-1:0]   mem [DEPTH_WORDS];

   // decoded view of the live request
   logic [31:0]       offset;
   logic [31:0]       word;
   logic              req_err;
   logic [IDX_W-1:0]  req_idx;

   // operands seen by the commit edge
   logic              commit;
   logic              c_we;
   logic [IDX_W-1:0]  c_idx;
   logic [XLEN-1:0]   c_wdata;
   logic [3:0]        c_wmask;
   logic              c_err;

   // Address decode: word index modulo 2^32, range check against base and depth
   always_comb begin
      offset  = req_addr_i - BASE_ADDR;
      word    = offset >> 2;
      req_err = (req_addr_i < BASE_ADDR) || (word >= 32'(DEPTH_WORDS));
      req_idx = word[IDX_W-1:0];
   end

   // Commit operands: with LATENCY=1 the commit happens on the accept edge
   // itself, so the live request is used instead of the captured copy.
   always_comb begin
      commit  = ((state == IDLE) && req_valid_i && (CNT_INIT == 4'd0)) ||
                ((state == WAIT) && (count == 4'd1));
      c_we    = we;
      c_idx   = idx;
      c_wdata = wdata;
      c_wmask = wmask;
      c_err   = err;
      if (state == IDLE) begin
         c_we    = req_we_i;
         c_idx   = req_idx;
         c_wdata = req_wdata_i;
         c_wmask = req_wmask_i;
         c_err   = req_err;
      end
   end

   // Control FSM with registered handshake outputs and response data
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         count       <= '0;
         we          <= 1'b0;
         idx         <= '0;
         wdata       <= '0;
         wmask       <= '0;
         err         <= 1'b0;
         req_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  we          <= req_we_i;
                  idx         <= req_idx;
                  wdata       <= req_wdata_i;
                  wmask       <= req_wmask_i;
                  err         <= req_err;
                  count       <= CNT_INIT;
                  req_ready_o <= 1'b0;
                  if (CNT_INIT == 4'd0) begin
                     state       <= RESP;
                     rsp_valid_o <= 1'b1;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               // counter reaches zero on the commit edge
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  state       <= RESP;
                  rsp_valid_o <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state       <= IDLE;
                  req_ready_o <= 1'b1;
                  rsp_valid_o <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               req_ready_o <= 1'b1;
               rsp_valid_o <= 1'b0;
            end
         endcase

         if (commit) begin
            rsp_rdata_o <= (c_we || c_err) ? '0 : mem[c_idx];
            rsp_err_o   <= c_err;
         end
      end
   end

   // Word array: byte-masked store on the commit edge, never reset
   always_ff @(posedge clk_i) begin
      if (rst_ni && commit && c_we && !c_err) begin
         for (int unsigned n = 0; n < 4; n++) begin
            if (c_wmask[n]) begin
               mem[c_idx][8*n +: 8] <= c_wdata[8*n +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// reset sequences and a randomized run against a byte-level memory model.
module tb_dmem_responder;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int unsigned DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: LATENCY=2
   logic        rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [3:0]  req_wmask;
   // DUT B: LATENCY=4
   logic        rst_n_b, req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
   logic [31:0] req_addr_b, req_wdata_b, rsp_rdata_b;
   logic [3:0]  req_wmask_b;

   dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err));

   dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(4)) dut_b (
      .clk_i(clk), .rst_ni(rst_n_b), .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
      .req_we_i(req_we_b), .req_addr_i(req_addr_b), .req_wdata_i(req_wdata_b), .req_wmask_i(req_wmask_b),
      .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b), .rsp_rdata_o(rsp_rdata_b), .rsp_err_o(rsp_err_b));

   int unsigned errors = 0;
   int unsigned checks = 0;

   // reference memory for DUT A, tracked per byte address arithmetic
   logic [31:0] model [DEPTH];

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: a byte address is inside the memory iff BASE <= a < BASE + 4*DEPTH
   function automatic void ref_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wmask, output logic [31:0] rdata, output logic err);
      longint unsigned a, lo, hi;
      int unsigned     w;
      a   = longint'(addr);
      lo  = longint'(BASE);
      hi  = lo + 4 * longint'(DEPTH);
      err = !(a >= lo && a < hi);
      rdata = 32'h0;
      if (!err) begin
         w = int'((a - lo) / 4);
         if (we) begin
            for (int n = 0; n < 4; n++)
               if (wmask[n]) model[w][8*n +: 8] = wdata[8*n +: 8];
         end else begin
            rdata = model[w];
         end
      end
   endfunction

   // One transaction on DUT A (b=0) or DUT B (b=1); starts and ends on a negedge.
   task automatic xact(input bit b, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input int unsigned hold,
                       output logic [31:0] rdata, output logic err);
      int unsigned t;
      int unsigned lat;
      t = 0;
      while (!(b ? req_ready_b : req_ready) && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("req_ready_timeout", 32'(b ? req_ready_b : req_ready), 32'h1);
      if (b) begin req_valid_b = 1; req_we_b = we; req_addr_b = addr; req_wdata_b = wdata; req_wmask_b = wmask; end
      else   begin req_valid   = 1; req_we   = we; req_addr   = addr; req_wdata   = wdata; req_wmask   = wmask; end
      @(posedge clk);
      @(negedge clk);
      chk("ready_low_after_accept", 32'(b ? req_ready_b : req_ready), 32'h0);
      lat = 1;
      while (!(b ? rsp_valid_b : rsp_valid) && lat < 40) begin
         // request lines wander while busy; only the accepted values count
         if (b) begin req_valid_b = 1'($urandom); req_we_b = 1'($urandom); req_addr_b = $urandom; req_wdata_b = $urandom; req_wmask_b = 4'($urandom); end
         else   begin req_valid   = 1'($urandom); req_we   = 1'($urandom); req_addr   = $urandom; req_wdata   = $urandom; req_wmask   = 4'($urandom); end
         @(negedge clk);
         lat++;
      end
      if (!(b ? rsp_valid_b : rsp_valid)) begin
         chk("rsp_timeout", 32'h0, 32'h1);
         req_valid = 0; req_valid_b = 0;
         rdata = 'x; err = 1'bx;
         return;
      end
      chk("latency", lat, b ? 32'd4 : 32'd2);
      rdata = b ? rsp_rdata_b : rsp_rdata;
      err   = b ? rsp_err_b : rsp_err;
      for (int i = 0; i < int'(hold); i++) begin
         if (b) req_valid_b = 1'($urandom); else req_valid = 1'($urandom);
         @(negedge clk);
         chk("hold_valid", 32'(b ? rsp_valid_b : rsp_valid), 32'h1);
         chk("hold_rdata", b ? rsp_rdata_b : rsp_rdata, rdata);
         chk("hold_err",   32'(b ? rsp_err_b : rsp_err), 32'(err));
         chk("hold_ready", 32'(b ? req_ready_b : req_ready), 32'h0);
      end
      if (b) begin req_valid_b = 0; rsp_ready_b = 1; end else begin req_valid = 0; rsp_ready = 1; end
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 0; rsp_ready_b = 0;
      chk("idle_valid", 32'(b ? rsp_valid_b : rsp_valid), 32'h0);
      chk("idle_ready", 32'(b ? req_ready_b : req_ready), 32'h1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, exp_rd, a, d;
      logic        er, exp_er;
      logic [3:0]  m;
      bit          seen;
      int unsigned t;

      rst_n = 0; rst_n_b = 0;
      req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wmask = '0; rsp_ready = 0;
      req_valid_b = 0; req_we_b = 0; req_addr_b = '0; req_wdata_b = '0; req_wmask_b = '0; rsp_ready_b = 0;

      // reset held for three cycles
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h1);
      chk("rst_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err",   32'(rsp_err), 32'h0);
      rst_n = 1; rst_n_b = 1;
      seen = 0;
      repeat (5) begin @(negedge clk); if (rsp_valid) seen = 1; end
      chk("no_spurious_rsp", 32'(seen), 32'h0);

      // directed vectors
      vecs.push_back('{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h8000_0002, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'h6, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h8000_0013, 32'h0,         4'h0, 32'h11BB_CC44, 1'b0});
      vecs.push_back('{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1});
      vecs.push_back('{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1});
      vecs.push_back('{1'b1, 32'h8000_0010, 32'h0,         4'h0, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'h11BB_CC44, 1'b0});
      vecs.push_back('{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h8000_0FFD, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0});
      vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1});
      vecs.push_back('{1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0, 1'b1});
      vecs.push_back('{1'b1, 32'h8000_0000, 32'h1234_5678, 4'h9, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h12AD_BE78, 1'b0});

      foreach (vecs[i]) begin
         xact(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
              (i == 1) ? 5 : i % 2, rd, er);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      end
      chk("bd_word0",    dut.mem[0],    32'h12AD_BE78);
      chk("bd_word4",    dut.mem[4],    32'h11BB_CC44);
      chk("bd_word1023", dut.mem[1023], 32'hCAFE_F00D);

      // reset while in RESP: the store has already landed, response dropped
      req_valid = 1; req_we = 1; req_addr = 32'h8000_0020; req_wdata = 32'h5A5A_0F0F; req_wmask = 4'hF;
      @(posedge clk); @(negedge clk);
      req_valid = 0;
      t = 0;
      while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
      chk("resp_before_reset", 32'(rsp_valid), 32'h1);
      rst_n = 0;
      #1;
      chk("reset_drops_rsp", 32'(rsp_valid), 32'h0);
      @(negedge clk); rst_n = 1; @(negedge clk);
      xact(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er);
      chk("resp_reset_store_kept", rd, 32'h5A5A_0F0F);

      // randomized run against the reference model over a 16-word window
      for (int w = 0; w < 16; w++) begin
         d = $urandom;
         ref_op(1'b1, BASE + 32'(4 * w), d, 4'hF, exp_rd, exp_er);
         xact(0, 1'b1, BASE + 32'(4 * w), d, 4'hF, 0, rd, er);
         chk("init_err", 32'(er), 32'(exp_er));
      end
      for (int i = 0; i < 80; i++) begin
         t = $urandom_range(0, 9);
         if (t == 0)      a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
         else if (t == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
         else             a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         d = $urandom;
         m = 4'($urandom);
         er = 1'($urandom);
         ref_op(er, a, d, m, exp_rd, exp_er);
         xact(0, er, a, d, m, $urandom_range(0, 2), rd, er);
         chk($sformatf("rnd%0d_rdata a=%h", i, a), rd, exp_rd);
         chk($sformatf("rnd%0d_err", i), 32'(er), 32'(exp_er));
      end
      for (int w = 0; w < 16; w++) chk($sformatf("bd_model_w%0d", w), dut.mem[w], model[w]);
      chk("bd_word1023_final", dut.mem[1023], 32'hCAFE_F00D);

      // LATENCY=4 instance: reset while WAIT drops the store
      xact(1, 1'b1, 32'h8000_0000, 32'h0, 4'hF, 0, rd, er);
      chk("b_init_rdata", rd, 32'h0);
      req_valid_b = 1; req_we_b = 1; req_addr_b = 32'h8000_0000; req_wdata_b = 32'h0000_00FF; req_wmask_b = 4'b0001;
      @(posedge clk); @(negedge clk);
      req_valid_b = 0;
      @(negedge clk);
      rst_n_b = 0;
      repeat (2) @(negedge clk);
      rst_n_b = 1;
      seen = 0;
      repeat (8) begin @(negedge clk); if (rsp_valid_b) seen = 1; end
      chk("b_no_rsp_after_reset", 32'(seen), 32'h0);
      chk("b_ready_after_reset", 32'(req_ready_b), 32'h1);
      chk("b_bd_word0", dut_b.mem[0], 32'h0);
      xact(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1, rd, er);
      chk("b_load_word0", rd, 32'h0);
      chk("b_load_err", 32'(er), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
